// File: rtl/pu_mc.sv
// Multi-cycle processing unit: FETCH/EXEC/MEM/WB sequencing over req/ack instruction and data ports.
// Zero-wait latency ALU/branch 2, ST/PUSH 3, LD/POP 4 cycles; requests hold until ack, so wait states only stretch a phase.
module pu_mc #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int PCW   = 8,
  parameter int DMAW  = 8,
  parameter int STKD  = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             im_req,
  output logic [PCW-1:0]   im_addr,
  input  logic             im_ack,
  input  logic [15:0]      im_rdata,
  output logic             dm_req,
  output logic             dm_we,
  output logic [DMAW-1:0]  dm_addr,
  output logic [WIDTH-1:0] dm_wdata,
  input  logic             dm_ack,
  input  logic [WIDTH-1:0] dm_rdata,
  output logic             we,
  output logic [WIDTH-1:0] rwd,
  output logic [PCW-1:0]   pc,
  output logic             halted,
  output logic             err
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int DW = $clog2(STKD + 1);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_BEZ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_PUSH = 4'hB;
  localparam logic [3:0] OP_POP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_ir;
  logic [PCW-1:0]   r_pc;
  logic [WIDTH-1:0] r_regs [NREG];
  logic [WIDTH-1:0] r_mdr;
  logic [DMAW-1:0]  r_sp;
  logic [DW-1:0]    r_depth;
  logic             r_err;

  logic [3:0]       w_op;
  logic [RW-1:0]    w_rd;
  logic [RW-1:0]    w_ra;
  logic [RW-1:0]    w_rb;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] w_alu;
  logic [PCW-1:0]   w_pc_inc;
  logic [PCW-1:0]   w_imm_pc;
  logic [PCW-1:0]   w_pc_nxt;
  logic [DMAW-1:0]  w_dm_addr;
  logic             w_is_wr;
  logic             w_is_rd;
  logic             w_stk_full;
  logic             w_stk_empty;
  logic             w_ir_ld;
  logic             w_mdr_ld;
  logic             w_mem_done;
  logic             w_rf_we;
  logic [WIDTH-1:0] w_rf_wd;
  logic             w_dm_req;
  logic             w_err_set;
  logic             w_unused;

  assign w_op     = r_ir[15:12];
  assign w_rd     = r_ir[8 +: RW];
  assign w_ra     = r_ir[4 +: RW];
  assign w_rb     = r_ir[0 +: RW];
  assign w_unused = ^r_ir[11:8];

  assign w_a = r_regs[w_ra];
  assign w_b = r_regs[w_rb];
  assign w_d = r_regs[w_rd];

  assign w_pc_inc = r_pc + PCW'(1);
  assign w_imm_pc = PCW'(r_ir[7:0]);

  assign w_is_wr     = (w_op == OP_ST) || (w_op == OP_PUSH);
  assign w_is_rd     = (w_op == OP_LD) || (w_op == OP_POP);
  assign w_stk_full  = (r_depth == DW'(STKD));
  assign w_stk_empty = (r_depth == '0);

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = w_a + w_b;
      OP_SUB:  w_alu = w_a - w_b;
      OP_AND:  w_alu = w_a & w_b;
      OP_OR:   w_alu = w_a | w_b;
      OP_XOR:  w_alu = w_a ^ w_b;
      OP_LDI:  w_alu = WIDTH'(r_ir[7:0]);
      default: w_alu = '0;
    endcase
  end

  // Stack grows downward: PUSH writes at sp, POP reads one above it.
  always_comb begin
    w_dm_addr = DMAW'(w_a);
    if (w_op == OP_PUSH) begin
      w_dm_addr = r_sp;
    end else if (w_op == OP_POP) begin
      w_dm_addr = r_sp + DMAW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_ld     = 1'b0;
    w_mdr_ld    = 1'b0;
    w_mem_done  = 1'b0;
    w_rf_we     = 1'b0;
    w_rf_wd     = '0;
    w_dm_req    = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (im_ack) begin
          w_ir_ld     = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI: begin
            w_rf_we     = 1'b1;
            w_rf_wd     = w_alu;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_FETCH;
          end
          OP_LD, OP_ST: begin
            w_state_nxt = S_MEM;
          end
          // Stack faults stop the core before any memory traffic or state change.
          OP_PUSH: begin
            if (w_stk_full) begin
              w_err_set   = 1'b1;
              w_state_nxt = S_HALT;
            end else begin
              w_state_nxt = S_MEM;
            end
          end
          OP_POP: begin
            if (w_stk_empty) begin
              w_err_set   = 1'b1;
              w_state_nxt = S_HALT;
            end else begin
              w_state_nxt = S_MEM;
            end
          end
          OP_BEZ: begin
            w_pc_nxt    = (w_d == '0) ? w_imm_pc : w_pc_inc;
            w_state_nxt = S_FETCH;
          end
          OP_JMP: begin
            w_pc_nxt    = w_imm_pc;
            w_state_nxt = S_FETCH;
          end
          OP_HALT: begin
            w_state_nxt = S_HALT;
          end
          default: begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        w_dm_req = 1'b1;
        if (dm_ack) begin
          w_mem_done = 1'b1;
          if (w_is_rd) begin
            w_mdr_ld    = 1'b1;
            w_state_nxt = S_WB;
          end else begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_WB: begin
        w_rf_we     = 1'b1;
        w_rf_wd     = r_mdr;
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = S_FETCH;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= '0;
      r_ir    <= '0;
      r_mdr   <= '0;
      r_sp    <= '1;
      r_depth <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_pc <= w_pc_nxt;
      if (w_ir_ld) begin
        r_ir <= im_rdata;
      end
      if (w_mdr_ld) begin
        r_mdr <= dm_rdata;
      end
      if (w_rf_we) begin
        r_regs[w_rd] <= w_rf_wd;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_mem_done && (w_op == OP_PUSH)) begin
        r_sp    <= r_sp - DMAW'(1);
        r_depth <= r_depth + DW'(1);
      end else if (w_mem_done && (w_op == OP_POP)) begin
        r_sp    <= r_sp + DMAW'(1);
        r_depth <= r_depth - DW'(1);
      end
    end
  end

  // Gated by rst so a pending fetch drops the instant reset asserts.
  assign im_req   = (r_state == S_FETCH) && rst;
  assign im_addr  = r_pc;
  assign dm_req   = w_dm_req;
  assign dm_we    = w_dm_req && w_is_wr;
  assign dm_addr  = w_dm_req ? w_dm_addr : '0;
  assign dm_wdata = (w_dm_req && w_is_wr) ? w_d : '0;
  assign we       = w_rf_we;
  assign rwd      = w_rf_wd;
  assign pc       = r_pc;
  assign halted   = (r_state == S_HALT);
  assign err      = r_err;

endmodule
